// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_NOT  = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_LSL  = 4'b0110,
        OP_LSR  = 4'b0111,
        OP_ASL  = 4'b1000,
        OP_ASR  = 4'b1001,
        OP_MULU = 4'b1010,
        OP_DIVU = 4'b1011,
        OP_REMU = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 0;

    // Opcodes that need the iterative multiply/divide engine.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide/remainder (restoring),
// one bit per cycle. A start pulse loads the operands; done_o flags the
// cycle in which the final iteration is being computed, and the result
// outputs carry that final value so the parent can register it on the same edge.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [3:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         carry_o,
    output logic         div0_o
);

    localparam int CW = $clog2(N + 1);

    // hi holds the upper product half (multiply) or the partial remainder (divide);
    // lo holds the multiplier/lower product (multiply) or dividend/quotient (divide).
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  opnd_q, opnd_d;
    logic [3:0]    op_q, op_d;

    logic [N-1:0]  hiStep, loStep;
    logic [N:0]    mulSum, divTrial, divDiff;

    // One iteration of either algorithm. A zero divisor never borrows, so the
    // quotient fills with ones and the remainder ends up equal to the dividend.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        divTrial = {hi_q, lo_q[N-1]};
        divDiff  = divTrial - {1'b0, opnd_q};
        if (op_q == OP_MULU) begin
            hiStep = mulSum[N:1];
            loStep = {mulSum[0], lo_q[N-1:1]};
        end else if (!divDiff[N]) begin
            hiStep = divDiff[N-1:0];
            loStep = {lo_q[N-2:0], 1'b1};
        end else begin
            hiStep = divTrial[N-1:0];
            loStep = {lo_q[N-2:0], 1'b0};
        end
    end

    // Load operands on start, then step while the down-counter is nonzero.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        if (start_i) begin
            cnt_d = CW'(N);
            op_d  = op_i;
            hi_d  = '0;
            if (op_i == OP_MULU) begin
                lo_d   = b_i;
                opnd_d = a_i;
            end else begin
                lo_d   = a_i;
                opnd_d = b_i;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = hiStep;
            lo_d  = loStep;
        end
    end

    // Engine state registers, cleared by reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
        end
    end

    // Final-iteration values presented to the parent alongside done.
    always_comb begin
        done_o   = (cnt_q == CW'(1));
        result_o = (op_q == OP_REMU) ? hiStep : loStep;
        carry_o  = (op_q == OP_MULU) && (hiStep != '0);
        div0_o   = (op_q != OP_MULU) && (opnd_q == '0);
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops are computed
// here at accept time; multiply/divide/remainder are delegated to alu_iter_muldiv.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ALUResult,
    output logic [3:0]   ALUFlags
);

    alu_state_e   state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;

    logic         accept;
    logic         mdStart, mdDone, mdCarry, mdDiv0;
    logic [N-1:0] mdResult;
    logic [N-1:0] singleRes;
    logic         singleC, singleV;
    logic [N:0]   addSum;

    function automatic logic [3:0] packFlags(input logic [N-1:0] res, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_N] = res[N-1];
        return f;
    endfunction

    assign accept = in_valid && in_ready;

    alu_iter_muldiv #(.N(N)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mdStart),
        .op_i     (ALUControl),
        .a_i      (A),
        .b_i      (B),
        .done_o   (mdDone),
        .result_o (mdResult),
        .carry_o  (mdCarry),
        .div0_o   (mdDiv0)
    );

    // Single-cycle operations evaluated directly on the live request operands.
    always_comb begin
        addSum    = '0;
        singleRes = '0;
        singleC   = 1'b0;
        singleV   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                addSum    = {1'b0, A} + {1'b0, B};
                singleRes = addSum[N-1:0];
                singleC   = addSum[N];
                singleV   = (A[N-1] == B[N-1]) && (addSum[N-1] != A[N-1]);
            end
            OP_SUB: begin
                addSum    = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
                singleRes = addSum[N-1:0];
                singleC   = addSum[N];
                singleV   = (A[N-1] != B[N-1]) && (addSum[N-1] != A[N-1]);
            end
            OP_AND: singleRes = A & B;
            OP_OR:  singleRes = A | B;
            OP_NOT: singleRes = ~A;
            OP_XOR: singleRes = A ^ B;
            OP_LSL, OP_ASL: begin
                singleRes = {A[N-2:0], 1'b0};
                singleC   = A[N-1];
            end
            OP_LSR: begin
                singleRes = {1'b0, A[N-1:1]};
                singleC   = A[0];
            end
            OP_ASR: begin
                singleRes = {A[N-1], A[N-1:1]};
                singleC   = A[0];
            end
            default: singleRes = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: iterative ops detour through EXEC until the engine reports done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_iterative(ALUControl) ? ST_EXEC : ST_HOLD;
            ST_EXEC: if (mdDone) state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; in_ready is also held low while reset is asserted.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_HOLD);
        mdStart   = in_valid && in_ready && is_iterative(ALUControl);
    end

    // Result/flag next value: loaded at accept for single-cycle ops, at done for iterative ones.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        if (accept && !is_iterative(ALUControl)) begin
            result_d = singleRes;
            flags_d  = packFlags(singleRes, singleC, singleV);
        end else if ((state_q == ST_EXEC) && mdDone) begin
            result_d = mdResult;
            flags_d  = packFlags(mdResult, mdCarry, mdDiv0);
        end
    end

    // Result and flag registers, stable throughout HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (N=8): directed corner cases followed
// by randomized operations checked against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 8;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_MULU = 4'd10;
    localparam logic [3:0] C_DIVU = 4'd11;
    localparam logic [3:0] C_REMU = 4'd12;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic [3:0]   ALUFlags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.N(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the operand values.
    task automatic refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] res, output logic [3:0] flags);
        int ua, ub, sa, sb, full, sfull;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        v = 1'b0;
        res = '0;
        case (op)
            4'd0: begin
                full = ua + ub;
                res = W'(full);
                c = (full >= (1 << W));
                sfull = sa + sb;
                v = (sfull > (1 << (W-1)) - 1) || (sfull < -(1 << (W-1)));
            end
            4'd1: begin
                res = W'(ua - ub);
                c = (ua >= ub);
                sfull = sa - sb;
                v = (sfull > (1 << (W-1)) - 1) || (sfull < -(1 << (W-1)));
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = ~a;
            4'd5: res = a ^ b;
            4'd6, 4'd8: begin
                res = W'(ua * 2);
                c = (ua >= (1 << (W-1)));
            end
            4'd7: begin
                res = W'(ua / 2);
                c = (ua % 2) == 1;
            end
            4'd9: begin
                res = W'(sa >>> 1);
                c = (ua % 2) == 1;
            end
            4'd10: begin
                full = ua * ub;
                res = W'(full);
                c = (full >= (1 << W));
            end
            4'd11: begin
                if (ub == 0) begin
                    res = W'((1 << W) - 1);
                    v = 1'b1;
                end else begin
                    res = W'(ua / ub);
                end
            end
            4'd12: begin
                if (ub == 0) begin
                    res = a;
                    v = 1'b1;
                end else begin
                    res = W'(ua % ub);
                end
            end
            default: res = '0;
        endcase
        flags = {v, (res == '0), c, res[W-1]};
    endtask

    // Present one request and leave the bench #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_before_request", 32'(in_ready), 32'd1);
        A = a;
        B = b;
        ALUControl = op;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        ALUControl = 4'($urandom_range(0, 15));
    endtask

    // Full transaction: request, latency, result, optional hold stall, release.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expRes, input logic [3:0] expFlags, input int holdCycles);
        int lat;
        int expLat;
        expLat = (op >= 4'd10 && op <= 4'd12) ? W + 1 : 1;
        applyStimulus(op, a, b);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_result"}, 32'(ALUResult), 32'(expRes));
        checkOutput({tag, "_flags"}, 32'(ALUFlags), 32'(expFlags));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_result"}, 32'(ALUResult), 32'(expRes));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0]   rOp;
        logic [W-1:0] rA, rB, eRes;
        logic [3:0]   eFlags;
        int           sawValid;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        ALUControl = '0;

        // Reset state
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(ALUResult), 32'd0);
        checkOutput("rst_flags", 32'(ALUFlags), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        $display("[TB] directed vectors");
        runOp("add_ovf", C_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001, 0);
        runOp("sub_zero", C_SUB, 8'h05, 8'h05, 8'h00, 4'b0110, 0);
        runOp("sub_neg", C_SUB, 8'h03, 8'h05, 8'hFE, 4'b0001, 0);
        runOp("mulu_ovf", C_MULU, 8'h10, 8'h10, 8'h00, 4'b0110, 0);
        runOp("mulu", C_MULU, 8'h0C, 8'h0A, 8'h78, 4'b0000, 1);
        runOp("divu", C_DIVU, 8'd200, 8'd7, 8'd28, 4'b0000, 0);
        runOp("remu", C_REMU, 8'd200, 8'd7, 8'd4, 4'b0000, 0);
        runOp("divu_by0", C_DIVU, 8'd9, 8'd0, 8'hFF, 4'b1001, 0);
        runOp("remu_by0", C_REMU, 8'd9, 8'd0, 8'd9, 4'b1000, 0);
        runOp("reserved", 4'b1110, 8'h5A, 8'hA5, 8'h00, 4'b0100, 0);

        // Back-pressure in HOLD with a competing request
        $display("[TB] hold stall");
        applyStimulus(C_ADD, 8'h22, 8'h11);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
            ALUControl = C_SUB;
            @(posedge clk); #1;
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_result", 32'(ALUResult), 32'h33);
            checkOutput("stall_flags", 32'(ALUFlags), 32'h0);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("stall_release_valid", 32'(out_valid), 32'd0);
        checkOutput("stall_release_ready", 32'(in_ready), 32'd1);
        sawValid = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) sawValid++;
        end
        checkOutput("stall_no_phantom", 32'(sawValid), 32'd0);

        // Reset in the 4th EXEC cycle of a multiply
        $display("[TB] reset during EXEC");
        applyStimulus(C_MULU, 8'h0C, 8'h0A);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("exec_not_done", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_result", 32'(ALUResult), 32'd0);
        checkOutput("mid_rst_flags", 32'(ALUFlags), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("after_rst_in_ready", 32'(in_ready), 32'd1);
        sawValid = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) sawValid++;
        end
        checkOutput("aborted_no_result", 32'(sawValid), 32'd0);
        runOp("add_after_rst", C_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 0);

        // Randomized operations against the reference model
        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            rOp = 4'($urandom_range(0, 15));
            rA  = W'($urandom);
            rB  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            refModel(rOp, rA, rB, eRes, eFlags);
            runOp($sformatf("rand%0d_op%0d", i, rOp), rOp, rA, rB, eRes, eFlags, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width, N >= 4.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port A  input  N  first operand.
REQ-007 SHALL have port B  input  N  second operand.
REQ-008 SHALL have port ALUControl  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port ALUResult  output  N  registered result.
REQ-012 SHALL have port ALUFlags  output  4  registered flags: [3]=V, [2]=Z, [1]=C, [0]=N.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and HOLD.
REQ-014 SHALL hold in_ready=1 only in IDLE; a request is accepted on in_valid&in_ready, and A, B and ALUControl are captured.
REQ-015 SHALL ignore in_valid and operand changes outside IDLE.
REQ-016 SHALL, for single-cycle ops, register the result and flags and enter HOLD: out_valid=1 exactly 1 cycle after accept.
REQ-017 SHALL, for MULU/DIVU/REMU, enter EXEC, iterate for exactly N cycles under a down-counter, then enter HOLD: out_valid=1 exactly N+1 cycles after accept.
REQ-018 SHALL, in HOLD, keep out_valid, ALUResult and ALUFlags stable until out_ready=1, then return to IDLE on the next edge; out_ready is ignored outside HOLD.
REQ-019 SHALL decode opcodes as follows:
- 0000 ADD
- 0001 SUB (A+~B+1)
- 0010 AND
- 0011 OR
- 0100 NOT A
- 0101 XOR
- 0110 LSL by 1
- 0111 LSR by 1
- 1000 ASL by 1
- 1001 ASR by 1
- 1010 MULU (low N bits)
- 1011 DIVU (quotient)
- 1100 REMU (remainder)
- 1101-1111 reserved
REQ-020 SHALL compute flag N as ALUResult[N-1] and flag Z as (ALUResult==0) for every op.
REQ-021 SHALL compute flag C as follows:
- ADD/SUB: adder carry-out (SUB: 1 = no borrow).
- Shifts: the bit shifted out.
- MULU: 1 if the upper N bits of the 2N-bit product are nonzero.
- All other ops: 0.
REQ-022 SHALL compute flag V as follows:
- ADD/SUB: signed overflow.
- DIVU/REMU with B==0: 1.
- All other ops: 0.
REQ-023 SHALL implement MULU as unsigned shift-add and DIVU/REMU as unsigned restoring division, one bit per EXEC cycle.
REQ-024 SHALL, on divide-by-zero, return all-ones for DIVU and A for REMU, with latency unchanged (N+1).
REQ-025 SHALL, for reserved opcodes, return ALUResult=0 and ALUFlags=4'b0100 with single-cycle latency.

Reset
REQ-026 SHALL, while rst=1, force the FSM to IDLE, the counter and all datapath registers to 0, ALUResult=0, ALUFlags=0, out_valid=0 and in_ready=0.
REQ-027 SHALL, when rst is asserted mid-EXEC or mid-HOLD, abandon the operation with no result ever presented; in_ready=1 on the first edge after rst deasserts.

Structure
REQ-028 SHALL place the opcode enum (alu_op_e), the FSM state enum (alu_state_e) and the flag bit-index constants (FLAG_V, FLAG_Z, FLAG_C, FLAG_N) in shared package alu_pkg.
REQ-029 SHALL isolate the iterative multiply/divide datapath and its counter in sub-module alu_iter_muldiv #(N), with start/done handshake to the parent FSM; single-cycle ops stay in the parent.

Verification (N=8)
REQ-030 SHALL cover: ADD 8'h7F+8'h01 -> ALUResult=8'h80, ALUFlags=4'b1001, out_valid 1 cycle after accept.
REQ-031 SHALL cover: SUB 8'h05-8'h05 -> 8'h00, ALUFlags=4'b0110; SUB 8'h03-8'h05 -> 8'hFE, ALUFlags=4'b0001.
REQ-032 SHALL cover: MULU 8'h10*8'h10 -> 8'h00, ALUFlags=4'b0110, out_valid exactly 9 cycles after accept; MULU 8'h0C*8'h0A -> 8'h78, ALUFlags=4'b0000.
REQ-033 SHALL cover: DIVU 8'd200/8'd7 -> 8'd28 (ALUFlags 4'b0000); REMU -> 8'd4; DIVU 8'd9/8'd0 -> 8'hFF, ALUFlags=4'b1001; REMU 8'd9/8'd0 -> 8'd9, ALUFlags=4'b1000.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in HOLD -> result and flags stable, in_ready=0, a concurrent in_valid with new operands is ignored; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: rst pulsed on the 4th EXEC cycle of MULU -> all outputs 0 and no out_valid; a following ADD 8'h01+8'h01 -> 8'h02, ALUFlags=4'b0000.
